// File: rtl/mul_seq_pkg.sv
// Shared widths, flag positions, ALU op codes and FSM encoding
// for the sequential shift-and-add multiplier.
package mul_seq_pkg;

    localparam int FULLW   = 32;
    localparam int ALUAW   = 4;
    localparam int FLAGS_W = 4;
    localparam int CNTW    = 5;

    // NZCV ordering of the flags vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [ALUAW-1:0] ALU_IDLE = 4'd0;
    localparam logic [ALUAW-1:0] ALU_ADD  = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Z and N of a value; C and V are never produced here
    function automatic logic [FLAGS_W-1:0] nz_flags(
        input logic [FULLW-1:0] v
    );
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = (v == '0);
        f[FLAG_N] = v[FULLW-1];
        return f;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential 32x32->32 multiplier using a shared external ALU.
// Ports: clk, reset (async high), start/opa/opb/set_flags request,
//   alu_code/alu_rn/alu_shifter -> ALU, alu_out <- ALU,
//   busy, done pulse, result, flags_out (Z,N), flags_nz_we.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FULLW-1:0]   opa,
    input  logic [FULLW-1:0]   opb,
    input  logic               set_flags,
    output logic [ALUAW-1:0]   alu_code,
    output logic [FULLW-1:0]   alu_rn,
    output logic [FULLW-1:0]   alu_shifter,
    input  logic [FULLW-1:0]   alu_out,
    output logic               busy,
    output logic               done,
    output logic [FULLW-1:0]   result,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               flags_nz_we
);

    state_e             state_q,  state_d;
    logic [FULLW-1:0]   acc_q,    acc_d;
    logic [FULLW-1:0]   mcand_q,  mcand_d;
    logic [FULLW-1:0]   mplier_q, mplier_d;
    logic [CNTW-1:0]    count_q,  count_d;
    logic               sflag_q,  sflag_d;
    logic [FULLW-1:0]   result_q, result_d;
    logic [FLAGS_W-1:0] flags_q,  flags_d;
    logic               accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            sflag_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            sflag_q  <= sflag_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        sflag_d     = sflag_q;
        result_d    = result_q;
        flags_d     = flags_q;
        alu_code    = ALU_IDLE;
        alu_rn      = '0;
        alu_shifter = '0;
        accept      = start && (state_q != S_ITER);

        unique case (state_q)
            S_ITER: begin
                // ALU always adds; a zero shifter operand means "skip"
                alu_code = ALU_ADD;
                alu_rn   = acc_q;
                if (mplier_q[0]) begin
                    alu_shifter = mcand_q;
                    acc_d       = alu_out;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (mplier_d == '0 || count_q == 5'd31) begin
                    state_d  = S_DONE;
                    result_d = acc_d;
                    flags_d  = nz_flags(acc_d);
                end
            end
            S_IDLE, S_DONE: begin
                if (accept) begin
                    acc_d    = '0;
                    mcand_d  = opa;
                    mplier_d = opb;
                    count_d  = '0;
                    sflag_d  = set_flags;
                    if (opb == '0) begin
                        // nothing to iterate: finish on the next cycle
                        state_d  = S_DONE;
                        result_d = '0;
                        flags_d  = nz_flags('0);
                    end else begin
                        state_d = S_ITER;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_ITER);
    assign done        = (state_q == S_DONE);
    assign flags_nz_we = done && sflag_q;
    assign result      = result_q;
    assign flags_out   = flags_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq with a behavioural ALU.
// Expected products and done cycles are queued at issue time.
module tb_mul_seq;
    import mul_seq_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic [FULLW-1:0]   opa;
    logic [FULLW-1:0]   opb;
    logic               set_flags;
    logic [ALUAW-1:0]   alu_code;
    logic [FULLW-1:0]   alu_rn;
    logic [FULLW-1:0]   alu_shifter;
    logic [FULLW-1:0]   alu_out;
    logic               busy;
    logic               done;
    logic [FULLW-1:0]   result;
    logic [FLAGS_W-1:0] flags_out;
    logic               flags_nz_we;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic        we;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    mul_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opa         (opa),
        .opb         (opb),
        .set_flags   (set_flags),
        .alu_code    (alu_code),
        .alu_rn      (alu_rn),
        .alu_shifter (alu_shifter),
        .alu_out     (alu_out),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flags_out   (flags_out),
        .flags_nz_we (flags_nz_we)
    );

    assign alu_out = (alu_code == ALU_ADD) ? alu_rn + alu_shifter : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int lat_of(input logic [31:0] b);
        int l;
        l = 0;
        for (int i = 0; i < 32; i++)
            if (b[i]) l = i + 1;
        return l;
    endfunction

    function automatic exp_t mk(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic s,
                                input int acc_cyc);
        exp_t e;
        logic [31:0] p;
        p       = a * b;
        e.res   = p;
        e.flg   = 4'b0000;
        e.flg[3] = p[31];
        e.flg[2] = (p == 32'd0);
        e.we    = s;
        e.cyc   = acc_cyc + lat_of(b);
        return e;
    endfunction

    // Output monitor: sampled 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        if (!busy) begin
            chk("alu_idle", {alu_code, alu_rn, alu_shifter}, 64'd0);
        end
        if (!done) begin
            if (flags_nz_we) chk("we_outside_done", 1, 0);
        end else if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("flags", flags_out, e.flg);
            chk("flags_we", flags_nz_we, e.we);
            chk("done_cycle", cyc, e.cyc);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done_neg();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 1, 0);
    endtask

    task automatic issue(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic s);
        @(negedge clk);
        start     = 1'b1;
        opa       = a;
        opb       = b;
        set_flags = s;
        exp_q.push_back(mk(a, b, s, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        opa       = '0;
        opb       = '0;
        set_flags = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_we", flags_nz_we, 0);
        reset = 1'b0;

        issue(32'd3, 32'd5, 1'b1);
        wait_idle();
        issue(32'd7, 32'd0, 1'b1);
        wait_idle();
        issue(32'd1, 32'h8000_0000, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        issue(32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_idle();

        // start during ITER must be ignored
        issue(32'd3, 32'd5, 1'b1);
        start = 1'b1;
        opa   = 32'd100;
        opb   = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // back-to-back: start in the DONE cycle
        issue(32'd9, 32'd6, 1'b1);
        wait_done_neg();
        start     = 1'b1;
        opa       = 32'd11;
        opb       = 32'd13;
        set_flags = 1'b0;
        exp_q.push_back(mk(32'd11, 32'd13, 1'b0, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high re-accepts on every DONE
        @(negedge clk);
        start     = 1'b1;
        opa       = 32'd5;
        opb       = 32'd3;
        set_flags = 1'b1;
        exp_q.push_back(mk(32'd5, 32'd3, 1'b1, cyc + 1));
        for (int k = 0; k < 2; k++) begin
            wait_done_neg();
            exp_q.push_back(mk(32'd5, 32'd3, 1'b1, cyc + 1));
        end
        wait_done_neg();
        start = 1'b0;
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (k < 4) ? 32'($urandom_range(255)) : $urandom;
            issue(a, b, k[0]);
            wait_idle();
        end

        // reset mid-ITER abandons the operation
        issue(32'd1, 32'h8000_0000, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_idle", {busy, done}, 0);

        issue(32'd6, 32'd7, 1'b1);
        wait_idle();
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
